// File: rtl/imm_gen_pipe.sv
// Immediate decoder for RV32I/RV64I formats feeding a registered valid/ready
// stage (OUT register plus one skid entry), with a saturating illegal-format counter.
module imm_gen_pipe #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned TAG_W        = 5,
  parameter int unsigned CNT_W        = 8,
  parameter logic [63:0] ILLEGAL_FILL = 64'h0000_0000_DEAD_BEEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [31:0]       instr_i,
  input  logic [2:0]        immsrc_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [XLEN-1:0]   imm_o,
  output logic              err_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [CNT_W-1:0]  err_count_o
);

  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_S = 3'd1,
    FMT_B = 3'd2,
    FMT_U = 3'd3,
    FMT_J = 3'd4,
    FMT_Z = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic             err;
    logic [TAG_W-1:0] tag;
  } beat_t;

  beat_t            r_out;
  beat_t            r_skid;
  logic             r_out_v;
  logic             r_skid_v;
  logic [CNT_W-1:0] r_cnt;

  beat_t            w_beat;
  logic             w_accept;
  logic             w_out_free;
  logic             w_unused_opcode;

  assign w_unused_opcode = ^instr_i[6:0];

  // Sign extension comes from sizing a $signed operand up to XLEN.
  always_comb begin
    w_beat     = '0;
    w_beat.tag = tag_i;
    case (immsrc_i)
      FMT_I:   w_beat.imm = XLEN'($signed(instr_i[31:20]));
      FMT_S:   w_beat.imm = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
      FMT_B:   w_beat.imm = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                           instr_i[11:8], 1'b0}));
      FMT_U:   w_beat.imm = XLEN'($signed({instr_i[31:12], 12'b0}));
      FMT_J:   w_beat.imm = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                           instr_i[30:21], 1'b0}));
      FMT_Z:   w_beat.imm = XLEN'(instr_i[19:15]);
      default: begin
        w_beat.imm = ILLEGAL_FILL[XLEN-1:0];
        w_beat.err = 1'b1;
      end
    endcase
  end

  assign ready_o    = !r_skid_v;
  assign w_accept   = valid_i && ready_o && !flush_i;
  assign w_out_free = !r_out_v || ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out    <= '0;
      r_skid   <= '0;
      r_out_v  <= 1'b0;
      r_skid_v <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (flush_i) begin
        r_out_v  <= 1'b0;
        r_skid_v <= 1'b0;
      end else if (r_skid_v && w_out_free) begin
        r_out    <= r_skid;
        r_out_v  <= 1'b1;
        r_skid_v <= 1'b0;
      end else if (w_accept && w_out_free) begin
        r_out   <= w_beat;
        r_out_v <= 1'b1;
      end else if (w_accept) begin
        r_skid   <= w_beat;
        r_skid_v <= 1'b1;
      end else if (ready_i && r_out_v) begin
        r_out_v <= 1'b0;
      end

      if (w_accept && w_beat.err && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign valid_o     = r_out_v;
  assign imm_o       = r_out.imm;
  assign err_o       = r_out.err;
  assign tag_o       = r_out.tag;
  assign err_count_o = r_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit/2-bit-counter instance and a 64-bit instance
// share stimulus and are compared each cycle against a queue-based reference.
module tb_imm_gen_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, valid_i, ready_i;
  logic [31:0] instr_i;
  logic [2:0]  immsrc_i;
  logic [4:0]  tag_i;

  logic        a_ready, a_valid, a_err;
  logic [31:0] a_imm;
  logic [4:0]  a_tag;
  logic [1:0]  a_cnt;
  logic        b_ready, b_valid, b_err;
  logic [63:0] b_imm;
  logic [4:0]  b_tag;
  logic [7:0]  b_cnt;

  always #5 clk_i = ~clk_i;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(2)) u_dut32 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(a_ready), .instr_i(instr_i), .immsrc_i(immsrc_i), .tag_i(tag_i),
    .valid_o(a_valid), .ready_i(ready_i), .imm_o(a_imm), .err_o(a_err),
    .tag_o(a_tag), .err_count_o(a_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(8)) u_dut64 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(b_ready), .instr_i(instr_i), .immsrc_i(immsrc_i), .tag_i(tag_i),
    .valid_o(b_valid), .ready_i(ready_i), .imm_o(b_imm), .err_o(b_err),
    .tag_o(b_tag), .err_count_o(b_cnt)
  );

  typedef struct {
    logic [63:0] imm;
    bit          err;
    logic [4:0]  tag;
  } beat_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [63:0] exp;
    bit          err;
  } vec_t;

  beat_t       q[$];
  int unsigned m_cnt_a, m_cnt_b;
  int          checks = 0;
  int          failures = 0;
  vec_t        tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Immediate value rebuilt from field positions with plain integer arithmetic.
  function automatic beat_t ref_beat(input logic [31:0] ins, input logic [2:0] src,
                                     input logic [4:0] tag);
    beat_t           b;
    longint unsigned u;
    longint unsigned raw;
    int              bits;
    u     = 64'(ins);
    b.tag = tag;
    b.err = 0;
    case (src)
      3'd0: begin raw = u >> 20; bits = 12; end
      3'd1: begin raw = (u >> 25) * 32 + ((u >> 7) & 31); bits = 12; end
      3'd2: begin
        raw  = ((u >> 31) & 1) * 4096 + ((u >> 7) & 1) * 2048
             + ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2;
        bits = 13;
      end
      3'd3: begin raw = (u >> 12) * 4096; bits = 32; end
      3'd4: begin
        raw  = ((u >> 31) & 1) * 1048576 + ((u >> 12) & 255) * 4096
             + ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2;
        bits = 21;
      end
      3'd5: begin raw = (u >> 15) & 31; bits = 64; end
      default: begin raw = 64'h0000_0000_DEAD_BEEF; bits = 64; b.err = 1; end
    endcase
    if (bits < 64 && raw >= (64'd1 << (bits - 1))) raw = raw - (64'd1 << bits);
    b.imm = raw;
    return b;
  endfunction

  task automatic model_edge();
    bit    acc;
    beat_t nb;
    if (rst_i) begin
      q.delete();
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else if (flush_i) begin
      q.delete();
    end else begin
      acc = valid_i && (q.size() < 2);
      if (ready_i && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        nb = ref_beat(instr_i, immsrc_i, tag_i);
        q.push_back(nb);
        if (nb.err) begin
          if (m_cnt_a < 3) m_cnt_a++;
          if (m_cnt_b < 255) m_cnt_b++;
        end
      end
    end
  endtask

  task automatic compare_model();
    bit exp_v;
    exp_v = q.size() > 0;
    chk("valid32", 64'(a_valid), 64'(exp_v));
    chk("valid64", 64'(b_valid), 64'(exp_v));
    chk("ready32", 64'(a_ready), 64'(q.size() < 2));
    chk("ready64", 64'(b_ready), 64'(q.size() < 2));
    chk("cnt32", 64'(a_cnt), 64'(m_cnt_a));
    chk("cnt64", 64'(b_cnt), 64'(m_cnt_b));
    if (exp_v) begin
      chk("imm32", 64'(a_imm), 64'(q[0].imm[31:0]));
      chk("imm64", b_imm, q[0].imm);
      chk("err32", 64'(a_err), 64'(q[0].err));
      chk("err64", 64'(b_err), 64'(q[0].err));
      chk("tag32", 64'(a_tag), 64'(q[0].tag));
      chk("tag64", 64'(b_tag), 64'(q[0].tag));
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    compare_model();
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [2:0] src,
                       input logic [4:0] tag);
    valid_i  = v;
    instr_i  = ins;
    immsrc_i = src;
    tag_i    = tag;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    tbl[0] = '{32'hFFF0_0093, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    tbl[1] = '{32'h7FF0_0013, 3'd0, 64'h0000_0000_0000_07FF, 0};
    tbl[2] = '{32'h8000_0F80, 3'd1, 64'hFFFF_FFFF_FFFF_F81F, 0};
    tbl[3] = '{32'hFE00_0EE3, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 0};
    tbl[4] = '{32'h1234_50B7, 3'd3, 64'h0000_0000_1234_5000, 0};
    tbl[5] = '{32'h8000_00B7, 3'd3, 64'hFFFF_FFFF_8000_0000, 0};
    tbl[6] = '{32'h8000_00EF, 3'd4, 64'hFFFF_FFFF_FFF0_0000, 0};
    tbl[7] = '{32'h000F_D073, 3'd5, 64'h0000_0000_0000_001F, 0};
    tbl[8] = '{32'hFFFF_FFFF, 3'd6, 64'h0000_0000_DEAD_BEEF, 1};
    tbl[9] = '{32'h0000_0000, 3'd7, 64'h0000_0000_DEAD_BEEF, 1};

    flush_i = 1'b0;
    ready_i = 1'b1;
    drive(1'b1, 32'hFFF0_0093, 3'd0, 5'd9);
    do_reset();
    do_reset();
    chk("rst_imm32", 64'(a_imm), 64'd0);
    chk("rst_imm64", b_imm, 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    chk("rst_tag", 64'(a_tag), 64'd0);
    chk("rst_valid", 64'(a_valid), 64'd0);
    chk("rst_ready", 64'(a_ready), 64'd1);

    // Format table, one beat per cycle with the sink always ready.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, tbl[i].instr, tbl[i].src, 5'(i + 5));
      tick();
      chk("tbl_valid", 64'(a_valid), 64'd1);
      chk("tbl_imm32", 64'(a_imm), 64'(tbl[i].exp[31:0]));
      chk("tbl_imm64", b_imm, tbl[i].exp);
      chk("tbl_err", 64'(b_err), 64'(tbl[i].err));
      chk("tbl_tag", 64'(a_tag), 64'(i + 5));
    end
    drive(1'b0, '0, 3'd0, '0);
    tick();

    // Backpressure: A to OUT, B to SKID, C held until space frees.
    do_reset();
    ready_i = 1'b0;
    drive(1'b1, 32'h0010_0013, 3'd0, 5'd1);
    tick();
    chk("bp_A_tag", 64'(a_tag), 64'd1);
    chk("bp_A_ready", 64'(a_ready), 64'd1);
    drive(1'b1, 32'h0020_0013, 3'd0, 5'd2);
    tick();
    chk("bp_B_ready", 64'(a_ready), 64'd0);
    chk("bp_B_tagA", 64'(a_tag), 64'd1);
    drive(1'b1, 32'h0030_0013, 3'd0, 5'd3);
    tick();
    chk("bp_C_held", 64'(a_tag), 64'd1);
    ready_i = 1'b1;
    tick();
    chk("bp_out_B", 64'(a_tag), 64'd2);
    chk("bp_ready_back", 64'(a_ready), 64'd1);
    tick();
    chk("bp_out_C", 64'(a_tag), 64'd3);
    chk("bp_imm_C", 64'(a_imm), 64'd3);
    drive(1'b0, '0, 3'd0, '0);
    tick();
    chk("bp_drained", 64'(a_valid), 64'd0);

    // Illegal beats: 2-bit counter saturates at 3, 8-bit keeps counting.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h1234_5678, 3'd6, 5'(i));
      tick();
      chk("ill_imm32", 64'(a_imm), 64'hDEAD_BEEF);
      chk("ill_err", 64'(a_err), 64'd1);
      chk("ill_cnt32", 64'(a_cnt), (i < 3) ? 64'(i + 1) : 64'd3);
      chk("ill_cnt64", 64'(b_cnt), 64'(i + 1));
    end

    // Flush with both entries full and an illegal beat presented alongside.
    ready_i = 1'b0;
    drive(1'b1, 32'h0040_0013, 3'd0, 5'd4);
    tick();
    drive(1'b1, 32'h0050_0013, 3'd0, 5'd5);
    tick();
    chk("fl_full", 64'(a_ready), 64'd0);
    flush_i = 1'b1;
    drive(1'b1, 32'h0, 3'd7, 5'd6);
    tick();
    flush_i = 1'b0;
    chk("fl_valid", 64'(a_valid), 64'd0);
    chk("fl_ready", 64'(a_ready), 64'd1);
    chk("fl_cnt64", 64'(b_cnt), 64'd5);
    drive(1'b0, '0, 3'd0, '0);
    tick();
    chk("fl_nodeliver", 64'(a_valid), 64'd0);
    // Flush while ready_o is high must still drop the illegal input.
    drive(1'b1, 32'h0060_0013, 3'd0, 5'd7);
    tick();
    flush_i = 1'b1;
    drive(1'b1, 32'h0, 3'd6, 5'd8);
    tick();
    flush_i = 1'b0;
    chk("fl2_cnt64", 64'(b_cnt), 64'd5);
    chk("fl2_valid", 64'(b_valid), 64'd0);

    // Z format then reset with SKID full.
    ready_i = 1'b1;
    drive(1'b1, 32'h000F_D073, 3'd5, 5'd10);
    tick();
    chk("z_imm", b_imm, 64'h1F);
    ready_i = 1'b0;
    drive(1'b1, 32'hFFF0_0093, 3'd0, 5'd11);
    tick();
    drive(1'b1, 32'hFFF0_0093, 3'd0, 5'd12);
    tick();
    chk("rs_full", 64'(a_ready), 64'd0);
    rst_i   = 1'b1;
    flush_i = 1'b1;
    tick();
    rst_i   = 1'b0;
    flush_i = 1'b0;
    chk("rs_valid", 64'(a_valid), 64'd0);
    chk("rs_ready", 64'(a_ready), 64'd1);
    chk("rs_imm", b_imm, 64'd0);
    chk("rs_tag", 64'(a_tag), 64'd0);
    chk("rs_err", 64'(a_err), 64'd0);
    chk("rs_cnt", 64'(b_cnt), 64'd0);

    // Randomised traffic against the reference queue.
    for (int n = 0; n < 3000; n++) begin
      ready_i = ($urandom_range(0, 99) < 65);
      flush_i = ($urandom_range(0, 99) < 4);
      rst_i   = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 99) < 70, $urandom, 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 31)));
      tick();
    end
    rst_i   = 1'b0;
    flush_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
